// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, immediate-select and result-select codes plus the control bundle types.
// No logic here; no latency and no backpressure of its own.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ASRC_RS1  = 2'b00;
  localparam logic [1:0] ASRC_PC   = 2'b01;
  localparam logic [1:0] ASRC_ZERO = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc is consumed in Decode only, so it is not part of the pipelined bundle.
  typedef struct packed {
    logic       regWrite;
    logic       aluSrc;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       branch;
    logic [1:0] aluOp;
    logic       jump;
    logic       jumpReg;
    logic [1:0] aluASrc;
    logic       valid;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
  } memCtrl_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
  } wbCtrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/rv_opcode_decoder.sv
// Combinational RV32I main decoder: opcode to control bundle and immediate select, zero latency.
// No backpressure; illegal opcodes yield an all-zero bundle with only valid/illegal set.
module rv_opcode_decoder
  import rv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_UJ   = 1'b1,
  parameter bit KILL_ILLEGAL = 1'b1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic [2:0] immSrc
);

  logic isIllegal;
  ctrl_t raw;

  always_comb begin
    raw       = CTRL_BUBBLE;
    raw.valid = 1'b1;
    immSrc    = IMM_I;
    isIllegal = 1'b0;
    case (op)
      OP_LOAD:  begin raw.regWrite = 1'b1; raw.aluSrc = 1'b1; raw.resultSrc = RES_MEM; end
      OP_STORE: begin raw.memWrite = 1'b1; raw.aluSrc = 1'b1; immSrc = IMM_S; end
      OP_R:     begin raw.regWrite = 1'b1; raw.aluOp = ALUOP_FUNCT; end
      OP_I:     begin raw.regWrite = 1'b1; raw.aluSrc = 1'b1; raw.aluOp = ALUOP_FUNCT; end
      OP_BR:    begin raw.branch = 1'b1; raw.aluOp = ALUOP_SUB; immSrc = IMM_B; end
      OP_JAL: begin
        raw.regWrite = 1'b1; raw.resultSrc = RES_PC4; raw.jump = 1'b1; immSrc = IMM_J;
        isIllegal = !SUPPORT_UJ;
      end
      OP_JALR: begin
        raw.regWrite = 1'b1; raw.aluSrc = 1'b1; raw.resultSrc = RES_PC4;
        raw.jump = 1'b1; raw.jumpReg = 1'b1;
        isIllegal = !SUPPORT_UJ;
      end
      OP_LUI: begin
        raw.regWrite = 1'b1; raw.aluSrc = 1'b1; raw.aluASrc = ASRC_ZERO; immSrc = IMM_U;
        isIllegal = !SUPPORT_UJ;
      end
      OP_AUIPC: begin
        raw.regWrite = 1'b1; raw.aluSrc = 1'b1; raw.aluASrc = ASRC_PC; immSrc = IMM_U;
        isIllegal = !SUPPORT_UJ;
      end
      default: isIllegal = 1'b1;
    endcase
    // Illegal ops still travel down the pipe, but can never write anything.
    if (isIllegal) begin
      raw         = CTRL_BUBBLE;
      raw.valid   = 1'b1;
      raw.illegal = KILL_ILLEGAL;
      immSrc      = IMM_I;
    end
  end

  assign ctrl = raw;

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX, EX/MEM, MEM/WB control registers fed by the opcode decoder; 1/2/3 cycles to E/M/W fields.
// stallE holds ID/EX and bubbles EX/MEM; flushE bubbles ID/EX and overrides stallE.
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter bit          SUPPORT_UJ   = 1'b1,
  parameter int unsigned CNT_W        = 8,
  parameter bit          KILL_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opD,
  input  logic             validD,
  input  logic             stallE,
  input  logic             flushE,
  output logic [2:0]       ImmSrcD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             JumpRegE,
  output logic             ValidE,
  output logic             IllegalE,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ALUOpE,
  output logic [1:0]       ALUASrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t    decCtrl, nextE, idEx;
  memCtrl_t exMem;
  wbCtrl_t  memWb;
  logic     loadE;

  rv_opcode_decoder #(
    .SUPPORT_UJ  (SUPPORT_UJ),
    .KILL_ILLEGAL(KILL_ILLEGAL)
  ) uDecoder (
    .op    (opD),
    .ctrl  (decCtrl),
    .immSrc(ImmSrcD)
  );

  assign nextE = validD ? decCtrl : CTRL_BUBBLE;
  assign loadE = !flushE && !stallE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idEx          <= CTRL_BUBBLE;
      exMem         <= '0;
      memWb         <= '0;
      illegal_count <= '0;
    end else begin
      if (flushE)       idEx <= CTRL_BUBBLE;
      else if (!stallE) idEx <= nextE;
      exMem <= stallE ? memCtrl_t'('0) : memCtrl_t'{idEx.regWrite, idEx.memWrite, idEx.resultSrc};
      memWb <= wbCtrl_t'{exMem.regWrite, exMem.resultSrc};
      if (loadE && nextE.illegal && illegal_count != CNT_MAX)
        illegal_count <= illegal_count + 1'b1;
    end
  end

  assign RegWriteE  = idEx.regWrite;
  assign MemWriteE  = idEx.memWrite;
  assign ALUSrcE    = idEx.aluSrc;
  assign BranchE    = idEx.branch;
  assign JumpE      = idEx.jump;
  assign JumpRegE   = idEx.jumpReg;
  assign ValidE     = idEx.valid;
  assign IllegalE   = idEx.illegal;
  assign ResultSrcE = idEx.resultSrc;
  assign ALUOpE     = idEx.aluOp;
  assign ALUASrcE   = idEx.aluASrc;
  assign RegWriteM  = exMem.regWrite;
  assign MemWriteM  = exMem.memWrite;
  assign ResultSrcM = exMem.resultSrc;
  assign RegWriteW  = memWb.regWrite;
  assign ResultSrcW = memWb.resultSrc;

endmodule
